lsu_port_arbiter: RTL and testbench

Arbitrates one data-cache request port between `NUM_PORTS` LSU requesters, such as the load unit, the store buffer and the page-table walker. Request/grant handshakes are forwarded to the cache. An in-order ID FIFO routes each `mem_rvalid_i` back to the requester that issued it. The block sits between the LSU requesters and a single `dcache_req_i_t`/`dcache_req_o_t` port pair, flattened here.

---
 rtl/lsu_port_arbiter.sv | 125 ++++++++++++
 tb/tb_lsu_port_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/lsu_port_arbiter.sv
// lsu_port_arbiter: shares one dcache request port among NUM_PORTS LSU requesters and routes responses back in order.
// Define LSU_PORT_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module lsu_port_arbiter #(
  parameter int NUM_PORTS       = 3,
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [NUM_PORTS-1:0]          req_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr_i,
  input  logic [NUM_PORTS-1:0]          we_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata_i,
  input  logic [NUM_PORTS*DATA_W/8-1:0] be_i,
  output logic [NUM_PORTS-1:0]          gnt_o,
  output logic [NUM_PORTS-1:0]          rvalid_o,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          mem_req_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic                          mem_we_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  output logic [DATA_W/8-1:0]           mem_be_o,
  input  logic                          mem_gnt_i,
  input  logic                          mem_rvalid_i,
  input  logic [DATA_W-1:0]             mem_rdata_i,
  output logic                          idle_o,
  output logic                          unexp_rsp_o
);
  localparam int IDW  = $clog2(NUM_PORTS);
  localparam int PW   = $clog2(MAX_OUTSTANDING);
  localparam int BE_W = DATA_W / 8;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] sel_q, sel_d;
  logic [PW:0]    cnt_q, cnt_d;
  logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [IDW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [IDW-1:0] fifo_d [MAX_OUTSTANDING];
  logic [IDW-1:0] start, win, cur;
  logic [IDW-1:0] cand [NUM_PORTS];
  logic           any_req, full, push, pop;

`ifdef LSU_PORT_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IDW-1:0] rr_q, rr_d;
  assign start = rr_q;
  assign rr_d  = push ? ((cur == IDW'(NUM_PORTS - 1)) ? '0 : cur + 1'b1) : rr_q;
  // round-robin pointer moves just past each granted port
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end
`endif

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cand
    assign cand[g] = IDW'((int'(start) + g) % NUM_PORTS);
  end

  // pick the first requester at or after the search start; later loop passes override earlier ones
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_i[cand[i]]) begin
        win     = cand[i];
        any_req = 1'b1;
      end
    end
  end

  assign cur         = (state_q == HOLD) ? sel_q : win;
  assign full        = cnt_q == (PW+1)'(MAX_OUTSTANDING);
  assign mem_req_o   = !flush_i && !full &&
                       ((state_q == IDLE && any_req) || (state_q == HOLD && req_i[sel_q]));
  assign push        = mem_req_o && mem_gnt_i;
  assign pop         = mem_rvalid_i && cnt_q != '0;
  assign mem_addr_o  = addr_i[int'(cur)*ADDR_W +: ADDR_W];
  assign mem_we_o    = we_i[cur];
  assign mem_wdata_o = wdata_i[int'(cur)*DATA_W +: DATA_W];
  assign mem_be_o    = be_i[int'(cur)*BE_W +: BE_W];
  assign gnt_o       = push ? NUM_PORTS'(1) << cur : '0;
  assign rvalid_o    = (pop && state_q != DRAIN) ? NUM_PORTS'(1) << fifo_q[rptr_q] : '0;
  assign rdata_o     = mem_rdata_i;
  assign unexp_rsp_o = mem_rvalid_i && cnt_q == '0;
  assign idle_o      = cnt_q == '0 && state_q == IDLE;

  // ID FIFO bookkeeping, HOLD lock capture and state transitions
  always_comb begin
    cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
    fifo_d = fifo_q;
    if (push) fifo_d[wptr_q] = cur;
    sel_d   = (state_q == IDLE && mem_req_o && !mem_gnt_i) ? win : sel_q;
    state_d = flush_i           ? DRAIN :
              (state_q == IDLE) ? ((mem_req_o && !mem_gnt_i) ? HOLD : IDLE) :
              (state_q == HOLD) ? ((push || !req_i[sel_q]) ? IDLE : HOLD) :
                                  ((cnt_d == '0) ? IDLE : DRAIN);
  end

  // state, lock and FIFO registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fifo_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fifo_q  <= fifo_d;
    end
  end
endmodule

// File: tb/tb_lsu_port_arbiter.sv
// tb_lsu_port_arbiter: directed scoreboard bench for lsu_port_arbiter.
module tb_lsu_port_arbiter;
  logic          clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
  logic [2:0]    req_i = '0, we_i = 3'b100;
  logic [191:0]  addr_i = {64'h3000, 64'h2000, 64'h1000};
  logic [191:0]  wdata_i = {64'hBEEF_0002, 64'hBEEF_0001, 64'hBEEF_0000};
  logic [23:0]   be_i = 24'h0F_F0_FF;
  logic [2:0]    gnt_o, rvalid_o;
  logic [63:0]   rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i = 64'h1234_5678;
  logic          mem_req_o, mem_we_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, idle_o, unexp_rsp_o;
  logic [7:0]    mem_be_o;

`ifdef LSU_PORT_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct { int port; logic [63:0] data; } rsp_t;
  rsp_t        exp_q[$];
  int          n_cmp = 0, n_err = 0;
  logic [63:0] next_data = 64'hA000;

  lsu_port_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .req_i(req_i), .addr_i(addr_i),
    .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .idle_o(idle_o),
    .unexp_rsp_o(unexp_rsp_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one cycle: drive at posedge+1, sample at negedge; ap/gp = -1 means no address/grant expected
  task automatic step(input string tag, input logic [2:0] req, input logic g, rv, mr,
                      input int ap, gp, input logic erv, ei, eu);
    rsp_t e;
    req_i        = req;
    mem_gnt_i    = g;
    mem_rvalid_i = rv;
    mem_rdata_i  = (rv && erv && exp_q.size() > 0) ? exp_q[0].data : {32'hDEAD_0000, $urandom};
    @(negedge clk_i);
    chk({tag, " mem_req"}, 64'(mem_req_o), 64'(mr));
    chk({tag, " gnt"}, 64'(gnt_o), (gp >= 0) ? 64'(1) << gp : 64'd0);
    if (ap >= 0) begin
      chk({tag, " addr"}, mem_addr_o, 64'(ap + 1) * 64'h1000);
      chk({tag, " wdata"}, mem_wdata_o, 64'hBEEF_0000 + 64'(ap));
      chk({tag, " we"}, 64'(mem_we_o), 64'(ap == 2));
    end
    if (rv && erv && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, " rvalid"}, 64'(rvalid_o), 64'(1) << e.port);
      chk({tag, " rdata"}, rdata_o, e.data);
    end else begin
      chk({tag, " rvalid"}, 64'(rvalid_o), 64'd0);
    end
    chk({tag, " idle"}, 64'(idle_o), 64'(ei));
    chk({tag, " unexp"}, 64'(unexp_rsp_o), 64'(eu));
    if (gp >= 0) begin
      exp_q.push_back('{gp, next_data});
      next_data++;
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst mem_req", 64'(mem_req_o), 64'd0);
    chk("rst gnt", 64'(gnt_o), 64'd0);
    chk("rst rvalid", 64'(rvalid_o), 64'd0);
    chk("rst rdata", rdata_o, 64'h1234_5678);
    chk("rst idle", 64'(idle_o), 64'd1);
    chk("rst unexp", 64'(unexp_rsp_o), 64'd0);
    rst_ni = 1'b1;

    // ports 0 and 2 stream, responses two cycles after each grant
    for (int k = 0; k < 8; k++)
      step("rr", (k < 6) ? 3'b101 : 3'b000, k < 6, k >= 2, k < 6,
           (k < 6) ? ((k % 2) ? 2 : 0) : -1, (k < 6) ? ((k % 2) ? 2 : 0) : -1,
           k >= 2, k == 0, 1'b0);

    // port 1 held through three stalled cycles while port 0 also asks
    step("hold0", 3'b010, 1'b0, 1'b0, 1'b1, 1, -1, 1'b0, 1'b1, 1'b0);
    step("hold1", 3'b011, 1'b0, 1'b0, 1'b1, 1, -1, 1'b0, 1'b0, 1'b0);
    step("hold2", 3'b011, 1'b0, 1'b0, 1'b1, 1, -1, 1'b0, 1'b0, 1'b0);
    step("hold3", 3'b011, 1'b1, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0);
    step("hold4", 3'b001, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (2) step("hold_rsp", 3'b000, 1'b0, 1'b1, 1'b0, -1, -1, 1'b1, 1'b0, 1'b0);

    // fill the ID FIFO, then show a same-cycle pop does not unblock a grant
    for (int k = 0; k < 4; k++)
      step("fill", 3'b001, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, k == 0, 1'b0);
    step("full", 3'b001, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0);
    step("full_pop", 3'b001, 1'b1, 1'b1, 1'b0, -1, -1, 1'b1, 1'b0, 1'b0);
    step("after_pop", 3'b001, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (4) step("full_rsp", 3'b000, 1'b0, 1'b1, 1'b0, -1, -1, 1'b1, 1'b0, 1'b0);

    // three outstanding, flush pulse, responses swallowed during drain
    for (int k = 0; k < 3; k++)
      step("pre_flush", 3'b100, 1'b1, 1'b0, 1'b1, 2, 2, 1'b0, k == 0, 1'b0);
    flush_i = 1'b1;
    step("flush", 3'b100, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0);
    flush_i = 1'b0;
    exp_q.delete();
    repeat (3) step("drain", 3'b100, 1'b1, 1'b1, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0);
    step("drained", 3'b000, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0, 1'b1, 1'b0);
    step("post_flush", 3'b100, 1'b1, 1'b0, 1'b1, 2, 2, 1'b0, 1'b1, 1'b0);
    step("post_rsp", 3'b000, 1'b0, 1'b1, 1'b0, -1, -1, 1'b1, 1'b0, 1'b0);

    // response with nothing outstanding
    step("unexp", 3'b000, 1'b0, 1'b1, 1'b0, -1, -1, 1'b0, 1'b1, 1'b1);
    step("unexp_end", 3'b000, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0, 1'b1, 1'b0);

    // reset with one ID outstanding discards it
    step("pre_rst", 3'b001, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0);
    req_i = '0;
    mem_gnt_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst idle", 64'(idle_o), 64'd1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    exp_q.delete();
    step("rst_unexp", 3'b000, 1'b0, 1'b1, 1'b0, -1, -1, 1'b0, 1'b1, 1'b1);

    // ports 0 and 1 contend: fixed priority keeps port 0, round-robin alternates
    for (int k = 0; k < 3; k++)
      step("prio", 3'b011, 1'b1, 1'b0, 1'b1, (FIXED || k % 2 == 0) ? 0 : 1,
           (FIXED || k % 2 == 0) ? 0 : 1, 1'b0, k == 0, 1'b0);
    repeat (3) step("prio_rsp", 3'b000, 1'b0, 1'b1, 1'b0, -1, -1, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
